// File: rtl/ws2812_encoder.sv
// WS2812 serial line encoder: one-pixel holding register feeding a 24-bit GRB shifter.
// Optional per-channel brightness scaling when WS2812_BRIGHTNESS_EN is defined.
module ws2812_encoder #(
  parameter int T0H   = 20,
  parameter int T1H   = 40,
  parameter int T_BIT = 63,
  parameter int T_RES = 2500
) (
  input  logic        clk,
  input  logic        rst,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]  brightness,
`endif
  input  logic [23:0] pix_data,
  input  logic        pix_last,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        ser_data,
  output logic        busy
);
  localparam int CMAX = (T_BIT > T_RES) ? T_BIT : T_RES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bit_q, bit_d;
  logic [23:0]   shift_q, shift_d;
  logic [23:0]   hold_data_q, hold_data_d;
  logic          cur_last_q, cur_last_d;
  logic          hold_last_q, hold_last_d;
  logic          hold_valid_q, hold_valid_d;
  logic          ser_q, ser_d;
  logic          accept, load;
  logic [23:0]   pix_in;
  logic [CW-1:0] thigh_m1;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] ch, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, ch} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
  assign pix_in = {scale(pix_data[23:16], brightness),
                   scale(pix_data[15:8],  brightness),
                   scale(pix_data[7:0],   brightness)};
`else
  assign pix_in = pix_data;
`endif

  assign pix_ready = !hold_valid_q && !rst;
  assign accept    = pix_valid && pix_ready;
  assign busy      = !rst && ((state_q != IDLE) || hold_valid_q);
  assign ser_data  = ser_q;
  assign thigh_m1  = shift_q[23] ? CW'(T1H - 1) : CW'(T0H - 1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    cur_last_d   = cur_last_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    load         = 1'b0;
    case (state_q)
      IDLE: if (hold_valid_q) load = 1'b1;
      HIGH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == thigh_m1) state_d = LOW;
      end
      LOW: begin
        if (cnt_q == CW'(T_BIT - 1)) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q - 5'd1;
            state_d = HIGH;
          end else if (cur_last_q) begin
            state_d = LATCH;
          end else if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH: begin
        if (cnt_q == CW'(T_RES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Reloading from hold at the end of bit 0 keeps the stream gap-free.
    if (load) begin
      shift_d      = hold_data_q;
      cur_last_d   = hold_last_q;
      hold_valid_d = 1'b0;
      bit_d        = 5'd23;
      cnt_d        = '0;
      state_d      = HIGH;
    end
    if (accept) begin
      hold_data_d  = pix_in;
      hold_last_d  = pix_last;
      hold_valid_d = 1'b1;
    end
    // Line follows the state one cycle late, giving the 2-cycle accept-to-rise latency.
    ser_d = (state_q == HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      cur_last_q   <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      ser_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      cur_last_q   <= cur_last_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      ser_q        <= ser_d;
    end
  end
endmodule

// File: tb/tb_ws2812_encoder.sv
// Scoreboard bench for ws2812_encoder: a line decoder rebuilds pixels and checks them
// against expected pixels queued at acceptance time.
module tb_ws2812_encoder;
  localparam int T0H = 20, T1H = 40, T_BIT = 63, T_RES = 2500;

  logic clk = 1'b0, rst;
  logic [23:0] pix_data;
  logic pix_last, pix_valid;
  logic pix_ready, ser_data, busy;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] brightness = 8'hFF;
`endif

  ws2812_encoder #(.T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RES(T_RES)) dut (
    .clk(clk), .rst(rst),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .pix_data(pix_data), .pix_last(pix_last), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .ser_data(ser_data), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { logic [23:0] data; bit last; int mode; } item_t;
  item_t sb[$];
  int errors = 0, checks = 0;
  int cyc = 0, acc_cyc = 0, last_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference scaling: channel * (b + 1) / 256 on each GRB byte.
  function automatic logic [23:0] model(input logic [23:0] d, input int b);
    int g, r, bl;
    g  = (int'(d[23:16]) * (b + 1)) / 256;
    r  = (int'(d[15:8])  * (b + 1)) / 256;
    bl = (int'(d[7:0])   * (b + 1)) / 256;
    return {g[7:0], r[7:0], bl[7:0]};
  endfunction

  // ---------------- monitor: decode the line ----------------
  bit prev = 0;
  int hi_len = 0, lo_len = 0, since_rise = 0, nbits = 0, h_prev = 0;
  logic [23:0] acc = '0;
  item_t it;

  always @(negedge clk) begin
    if (rst) begin
      prev = 0; hi_len = 0; lo_len = 0; since_rise = 0; nbits = 0; acc = '0;
    end else begin
      if (ser_data && !prev) begin
        if (nbits != 0) chk("bit_period", since_rise, T_BIT);
        else if (sb.size() == 0) chk("spurious_pixel_start", 1, 0);
        else if (sb[0].mode == 1) chk("contiguous_gap", lo_len, T_BIT - h_prev);
        else if (sb[0].mode == 2) chk("latch_gap", lo_len, T_BIT - h_prev + T_RES + 1);
        since_rise = 0; lo_len = 0;
      end
      if (!ser_data && prev) begin
        chk("pulse_width", hi_len, (hi_len > (T0H + T1H) / 2) ? T1H : T0H);
        acc = {acc[22:0], (hi_len > (T0H + T1H) / 2)};
        nbits++; h_prev = hi_len; hi_len = 0;
        if (nbits == 24) begin
          if (sb.size() > 0) begin
            it = sb.pop_front();
            chk("pixel_data", int'(acc), int'(it.data));
          end else chk("unexpected_pixel", 1, 0);
          nbits = 0;
        end
      end
      if (ser_data) hi_len++; else lo_len++;
      since_rise++;
      prev = ser_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [23:0] d, input bit last, input int mode,
                      input bit lat, input logic [23:0] expd);
    item_t x;
    int n = 0;
    pix_data = d; pix_last = last; pix_valid = 1'b1;
    while (!pix_ready && n < 5000) begin @(posedge clk); #2; n++; end
    if (n >= 5000) chk("accept_timeout", n, 0);
    @(posedge clk); #2;
    pix_valid = 1'b0;
    acc_cyc = cyc; last_wait = n;
    x.data = expd; x.last = last; x.mode = mode;
    sb.push_back(x);
    if (lat) begin
      chk("latency_c0", int'(ser_data), 0);
      @(posedge clk); #2; chk("latency_c1", int'(ser_data), 0);
      @(posedge clk); #2; chk("latency_c2", int'(ser_data), 1);
    end
  endtask

  task automatic wait_idle(input int exp);
    int n = 0;
    while (busy && n < 20000) begin @(posedge clk); #2; n++; end
    if (exp >= 0) chk("busy_fall_cycle", cyc - acc_cyc, exp);
    else chk("busy_fall_bounded", int'(busy), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hc, nf, np;
    logic [23:0] d;
    int b;
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    repeat (3) @(posedge clk); #2;
    chk("reset_ser", int'(ser_data), 0);
    chk("reset_ready", int'(pix_ready), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0; #1;
    chk("ready_after_reset", int'(pix_ready), 1);

    // single last pixel: 8 ones, 16 zeros, then latch
    send(24'hFF0000, 1'b1, 0, 1'b1, 24'hFF0000);
    wait_idle(1 + 24 * T_BIT + T_RES);

    // back-to-back pair must be one continuous 48-bit stream
    send(24'hAAAAAA, 1'b0, 0, 1'b1, 24'hAAAAAA);
    send(24'h555555, 1'b1, 1, 1'b0, 24'h555555);
    chk("pair_no_wait", last_wait, 0);
    wait_idle(48 * T_BIT + T_RES - 2);

    // underrun: non-last pixel with no successor returns to IDLE
    send(24'h000001, 1'b0, 0, 1'b1, 24'h000001);
    wait_idle(1 + 24 * T_BIT);
    chk("underrun_line_low", int'(ser_data), 0);
    repeat (20) @(posedge clk); #2;
    send(24'h00F00F, 1'b1, 0, 1'b1, 24'h00F00F);
    wait_idle(1 + 24 * T_BIT + T_RES);

    // pixel offered during LATCH is taken at once but waits for the latch
    send(24'h123456, 1'b1, 0, 1'b1, 24'h123456);
    repeat (24 * T_BIT + 50) @(posedge clk); #2;
    chk("in_latch_busy", int'(busy), 1);
    send(24'h654321, 1'b1, 2, 1'b0, 24'h654321);
    chk("latch_accept_immediate", last_wait, 0);
    wait_idle(-1);

    // reset during bit 10 aborts the pixel
    send(24'hC3A55A, 1'b0, 0, 1'b1, 24'hC3A55A);
    repeat (10 * T_BIT + 5) @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("abort_ser", int'(ser_data), 0);
    chk("abort_ready", int'(pix_ready), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_queue", sb.size(), 1);
    if (sb.size() > 0) void'(sb.pop_front());
    repeat (2) @(posedge clk); #2;
    rst = 1'b0; #1;
    chk("abort_ready_release", int'(pix_ready), 1);
    hc = 0;
    repeat (3 * T_BIT) begin @(posedge clk); #2; if (ser_data) hc++; end
    chk("abort_no_residual", hc, 0);

`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'h80;
    send(24'hFF4002, 1'b1, 0, 1'b1, 24'h802001);
    wait_idle(1 + 24 * T_BIT + T_RES);
    brightness = 8'hFF;
    send(24'hFF4002, 1'b1, 0, 1'b1, 24'hFF4002);
    wait_idle(1 + 24 * T_BIT + T_RES);
`endif

    // random frames with random inter-pixel gaps (some cause underrun)
    for (int f = 0; f < 4; f++) begin
      nf = $urandom_range(1, 3);
      b = $urandom_range(0, 255);
`ifdef WS2812_BRIGHTNESS_EN
      brightness = b[7:0];
`else
      b = 255;
`endif
      for (int p = 0; p < nf; p++) begin
        np = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 1600);
        repeat (np) @(posedge clk); #2;
        d = 24'($urandom);
        send(d, p == nf - 1, 0, 1'b0, model(d, b));
      end
      wait_idle(-1);
    end

    repeat (10) @(posedge clk); #2;
    chk("queue_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
